// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo_if
// Brief    : Write-side push handshake between the core and the UART TX FIFO.
// Revision : 1.0
// ============================================================================
interface uart_tx_fifo_if;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       wr_ready;

  modport master (output wr_en, output wr_data, input wr_ready);
  modport slave  (input wr_en, input wr_data, output wr_ready);
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : Buffered 8N1 UART transmitter with a power-of-2 byte FIFO.
// Revision : 1.0
// ============================================================================
module uart_tx_fifo #(
  parameter int CLK_HZ     = 16000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  uart_tx_fifo_if.slave               wr,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] level
);
  localparam int L     = $clog2(FIFO_DEPTH);
  localparam int DIV   = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state;
  logic [L:0]       wr_ptr;
  logic [L:0]       rd_ptr;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [7:0]       shift;
  logic [2:0]       bit_cnt;
  logic [CNT_W-1:0] baud_cnt;
  logic             full;
  logic             empty;
  logic             push;
  logic             bit_end;

  assign full        = (wr_ptr[L] != rd_ptr[L]) && (wr_ptr[L-1:0] == rd_ptr[L-1:0]);
  assign empty       = (wr_ptr == rd_ptr);
  assign push        = wr.wr_en && !full;
  assign wr.wr_ready = !full;
  assign level       = wr_ptr - rd_ptr;
  assign bit_end     = (baud_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[L-1:0]] <= wr.wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // tx and busy follow the state one cycle late, so every line level lasts
  // exactly DIV cycles and the pop edge precedes the start bit by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rd_ptr   <= '0;
      shift    <= '0;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
    end else begin
      busy <= (state != IDLE);
      case (state)
        IDLE:    tx <= 1'b1;
        START:   tx <= 1'b0;
        DATA:    tx <= shift[0];
        default: tx <= 1'b1;
      endcase

      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (!empty) begin
            shift   <= mem[rd_ptr[L-1:0]];
            rd_ptr  <= rd_ptr + 1'b1;
            bit_cnt <= '0;
            state   <= START;
          end
        end
        START: begin
          baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
          if (bit_end) begin
            state <= DATA;
          end
        end
        DATA: begin
          baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
          if (bit_end) begin
            if (bit_cnt == 3'd7) begin
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shift   <= shift >> 1;
            end
          end
        end
        default: begin
          baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
          if (bit_end) begin
            if (!empty) begin
              shift   <= mem[rd_ptr[L-1:0]];
              rd_ptr  <= rd_ptr + 1'b1;
              bit_cnt <= '0;
              state   <= START;
            end else begin
              state <= IDLE;
            end
          end
        end
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Brief    : Self-checking bench: line decoder plus expected-byte queue.
// Revision : 1.0
// ============================================================================
module tb_uart_tx_fifo;
  localparam int DIV   = (16000000 + 115200 / 2) / 115200;
  localparam int FRAME = 10 * DIV;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       tx;
  logic       busy;
  logic [3:0] level;

  uart_tx_fifo_if wr_if ();

  uart_tx_fifo #(
    .CLK_HZ    (16000000),
    .BAUD      (115200),
    .FIFO_DEPTH(8)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .wr   (wr_if),
    .tx   (tx),
    .busy (busy),
    .level(level)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] exp_q[$];
  int         starts_q[$];
  logic [9:0] last_frame;
  int         frames = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Line decoder: each bit's value is taken from its first cycle and must hold
  // for all DIV cycles of that bit.
  logic       prev_tx = 1'b1;
  logic       mon_on  = 1'b0;
  logic       mon_glitch;
  logic [9:0] mon_bits;
  int         mon_cnt;
  logic [7:0] exp_b;

  always @(negedge clk) begin
    if (rst) begin
      mon_on  = 1'b0;
      prev_tx = 1'b1;
      exp_q.delete();
    end else if (!mon_on) begin
      if (prev_tx && !tx) begin
        mon_on     = 1'b1;
        mon_cnt    = 0;
        mon_glitch = 1'b0;
        mon_bits   = '0;
        starts_q.push_back(cyc);
      end
      prev_tx = tx;
    end else begin
      mon_cnt++;
      if (mon_cnt % DIV == 0) mon_bits[mon_cnt/DIV] = tx;
      else if (tx !== mon_bits[mon_cnt/DIV]) mon_glitch = 1'b1;
      if (mon_cnt == FRAME - 1) begin
        mon_on     = 1'b0;
        prev_tx    = tx;
        last_frame = mon_bits;
        frames++;
        checks++;
        if (mon_glitch || mon_bits[0] !== 1'b0 || mon_bits[9] !== 1'b1) begin
          errors++;
          $display("FAIL framing: got bits %b glitch %0d expected start 0 stop 1 no glitch",
                   mon_bits, mon_glitch);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte: got %0h expected none", mon_bits[8:1]);
        end else begin
          exp_b = exp_q.pop_front();
          if (mon_bits[8:1] !== exp_b) begin
            errors++;
            $display("FAIL rx_byte: got %0h expected %0h", mon_bits[8:1], exp_b);
          end
        end
      end
    end
  end

  task automatic step(input int n);
    if (n > 0) repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, output logic acc);
    wr_if.wr_en   = 1'b1;
    wr_if.wr_data = d;
    acc = wr_if.wr_ready;
    @(posedge clk);
    #1;
    wr_if.wr_en   = 1'b0;
    wr_if.wr_data = 8'($urandom);
    if (acc) exp_q.push_back(d);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || mon_on || exp_q.size() != 0) && n < budget) begin
      step(1);
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy %0d queued %0d expected idle within %0d cycles",
               busy, exp_q.size(), budget);
    end
  endtask

  vec_t vecs[5];
  logic acc;
  logic [3:0] lvl_before;
  int fc;

  initial begin
    vecs[0] = '{8'h55, 10'b1_01010101_0};
    vecs[1] = '{8'hA5, 10'b1_10100101_0};
    vecs[2] = '{8'hFF, 10'b1_11111111_0};
    vecs[3] = '{8'h00, 10'b1_00000000_0};
    vecs[4] = '{8'h81, 10'b1_10000001_0};

    rst           = 1'b1;
    wr_if.wr_en   = 1'b0;
    wr_if.wr_data = 8'h00;
    step(3);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_level", level, 0);
    chk("rst_ready", wr_if.wr_ready, 1);
    rst = 1'b0;
    step(3);

    // Single frames into an idle block: latency, timing and bit order.
    foreach (vecs[i]) begin
      push(vecs[i].data, acc);
      chk("vec_accept", acc, 1);
      chk("vec_level_n", level, 1);
      chk("vec_tx_n", tx, 1);
      step(1);
      chk("vec_tx_n1", tx, 1);
      chk("vec_level_n1", level, 0);
      step(1);
      chk("vec_tx_n2", tx, 0);
      chk("vec_busy_n2", busy, 1);
      step(FRAME - 1);
      chk("vec_busy_last", busy, 1);
      step(1);
      chk("vec_busy_drop", busy, 0);
      wait_idle(4 * FRAME);
      chk("vec_frame", last_frame, vecs[i].frame);
    end

    // Burst until full, refused push, back-to-back frames.
    starts_q.delete();
    for (int i = 0; i < 9; i++) begin
      push(8'(i), acc);
      chk("burst_accept", acc, 1);
    end
    chk("full_level", level, 8);
    chk("full_ready", wr_if.wr_ready, 0);
    push(8'hAA, acc);
    chk("full_refused", acc, 0);
    chk("full_level_hold", level, 8);
    step(FRAME - 9);
    chk("full_ready_before_pop", wr_if.wr_ready, 0);
    step(1);
    chk("full_ready_after_pop", wr_if.wr_ready, 1);
    chk("full_level_after_pop", level, 7);
    wait_idle(11 * FRAME);
    chk("burst_frames", starts_q.size(), 9);
    for (int i = 1; i < starts_q.size(); i++)
      chk("burst_gap", starts_q[i] - starts_q[i-1], FRAME);

    // Push on the same edge as the STOP->START pop.
    for (int i = 0; i < 4; i++) push(8'h31 + 8'(i), acc);
    chk("pp_level_pre", level, 3);
    step(FRAME - 3);
    chk("pp_level_at", level, 3);
    push(8'h35, acc);
    chk("pp_accept", acc, 1);
    chk("pp_level_post", level, 3);
    wait_idle(6 * FRAME);

    // Async reset in the middle of the data bits.
    push(8'hC3, acc);
    for (int i = 0; i < 4; i++) push(8'h40 + 8'(i), acc);
    chk("mid_level", level, 4);
    step(5 * DIV);
    chk("mid_tx_before_rst", tx, 0);
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_ready", wr_if.wr_ready, 1);
    step(3);
    rst = 1'b0;
    step(2);
    fc = frames;
    push(8'h12, acc);
    wait_idle(2 * FRAME);
    step(3 * FRAME);
    chk("post_rst_frames", frames - fc, 1);
    chk("post_rst_byte", last_frame[8:1], 8'h12);

    // Randomised pushes with bursts that reach full.
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 3) == 0) step($urandom_range(100, 600));
      lvl_before = level;
      push(8'($urandom), acc);
      chk("rand_accept_iff_not_full", acc, (lvl_before != 4'd8));
    end
    wait_idle(20 * FRAME);
    chk("rand_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected finish within 100000 cycles");
    $fatal(1);
  end
endmodule
`default_nettype wire
